// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for decode-stage hazard tracking.
// Two combinational read ports, one write port, optional write->read forwarding, optional hard-wired zero register.
module regfile_sb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              read1Busy,
  output logic              read2Busy,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEn,
  input  logic              rsvEn,
  input  logic [ADDR_W-1:0] rsvRegSel,
  input  logic              flush,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              err_q, err_d;

  logic              wr_ok, rsv_ok;
  logic [ADDR_W-1:0] rd_sel  [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_busy [2];

  // Operations aimed at a hard-wired zero register are dropped entirely.
  always_comb begin
    wr_ok  = writeEn && !((ZERO_REG != 0) && (writeRegSel == '0));
    rsv_ok = rsvEn   && !((ZERO_REG != 0) && (rsvRegSel   == '0));
  end

  // Write clears busy, flush clears all, reserve sets last so a new producer wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    err_d  = 1'b0;
    if (wr_ok) begin
      mem_d[writeRegSel]  = writeData;
      busy_d[writeRegSel] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (rsv_ok && !flush) begin
      busy_d[rsvRegSel] = 1'b1;
    end
    if (wr_ok && !flush && !busy_q[writeRegSel]) begin
      err_d = 1'b1;
    end
    if (rsv_ok && busy_q[rsvRegSel] && !(wr_ok && (writeRegSel == rsvRegSel))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rd_sel[0] = read1RegSel;
    rd_sel[1] = read2RegSel;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_sel[p]];
      rd_busy[p] = busy_q[rd_sel[p]];
      if ((BYPASS != 0) && wr_ok && (writeRegSel == rd_sel[p])) begin
        rd_data[p] = writeData;
        rd_busy[p] = 1'b0;
      end
      if ((ZERO_REG != 0) && (rd_sel[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign read1Data = rd_data[0];
  assign read2Data = rd_data[1];
  assign read1Busy = rd_busy[0];
  assign read2Busy = rd_busy[1];
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances (default, no-bypass, zero-reg) share one stimulus stream.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  read1RegSel = '0, read2RegSel = '0, writeRegSel = '0, rsvRegSel = '0;
  logic [15:0] writeData = '0;
  logic        writeEn = 1'b0, rsvEn = 1'b0, flush = 1'b0;

  logic [15:0] a_d1, a_d2, n_d1, n_d2, z_d1, z_d2;
  logic        a_b1, a_b2, n_b1, n_b2, z_b1, z_b2;
  logic        a_err, n_err, z_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(a_d1), .read2Data(a_d2), .read1Busy(a_b1), .read2Busy(a_b2),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .rsvEn(rsvEn), .rsvRegSel(rsvRegSel), .flush(flush), .err(a_err)
  );

  regfile_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(n_d1), .read2Data(n_d2), .read1Busy(n_b1), .read2Busy(n_b2),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .rsvEn(rsvEn), .rsvRegSel(rsvRegSel), .flush(flush), .err(n_err)
  );

  regfile_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(z_d1), .read2Data(z_d2), .read1Busy(z_b1), .read2Busy(z_b2),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .rsvEn(rsvEn), .rsvRegSel(rsvRegSel), .flush(flush), .err(z_err)
  );

  typedef struct {
    logic        rsv;
    logic [2:0]  rsel;
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wd;
    logic        fl;
    logic [2:0]  s1, s2;
    logic [15:0] d1;
    logic        b1;
    logic [15:0] d2;
    logic        b2;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rsv, logic [2:0] rsel, logic we, logic [2:0] wsel,
                              logic [15:0] wd, logic fl, logic [2:0] s1, logic [2:0] s2,
                              logic [15:0] d1, logic b1, logic [15:0] d2, logic b2, logic er);
    vec_t v;
    v.rsv = rsv; v.rsel = rsel; v.we = we; v.wsel = wsel; v.wd = wd; v.fl = fl;
    v.s1 = s1; v.s2 = s2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rsv, input logic [2:0] rsel, input logic we, input logic [2:0] wsel,
                       input logic [15:0] wd, input logic fl, input logic [2:0] s1, input logic [2:0] s2);
    @(negedge clk);
    rsvEn = rsv; rsvRegSel = rsel; writeEn = we; writeRegSel = wsel;
    writeData = wd; flush = fl; read1RegSel = s1; read2RegSel = s2;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rsv rs we ws wd       fl s1 s2  d1       b1 d2       b2 er
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 7, 16'h0000, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 16'h0000, 0, 3, 3, 16'h0000, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 3, 3, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 3, 16'hBEEF, 0, 3, 3, 16'hBEEF, 0, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 3, 3, 16'hBEEF, 0, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 16'h1234, 0, 5, 3, 16'h1234, 0, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 5, 5, 16'h1234, 0, 16'h1234, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 5, 5, 16'h1234, 0, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2, 16'h00AA, 0, 2, 5, 16'h00AA, 0, 16'h1234, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 2, 2, 16'h00AA, 0, 16'h00AA, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 2, 2, 16'h00AA, 0, 16'h00AA, 0, 0));
    vecs.push_back(mk(1, 4, 0, 0, 16'h0000, 0, 4, 6, 16'h0000, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 6, 0, 0, 16'h0000, 0, 4, 6, 16'h0000, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 7, 0, 0, 16'h0000, 1, 4, 6, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 7, 4, 16'h0000, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 6, 3, 16'h0000, 0, 16'hBEEF, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 16'h5555, 0, 1, 2, 16'h5555, 0, 16'h00AA, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h5555, 1, 16'h5555, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 1, 1, 16'h5555, 1, 16'h5555, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h5555, 1, 16'h5555, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0F0F, 1, 1, 1, 16'h0F0F, 0, 16'h0F0F, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h0F0F, 0, 16'h0F0F, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h1111, 1, 0, 1, 16'h1111, 0, 16'h0F0F, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 0, 3, 16'h1111, 0, 16'hBEEF, 0, 0));

    rst = 1'b0;
    #1;
    chk("reset_d1", {16'h0, a_d1}, 32'h0);
    chk("reset_err", {31'h0, a_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rsv, vecs[i].rsel, vecs[i].we, vecs[i].wsel, vecs[i].wd, vecs[i].fl,
            vecs[i].s1, vecs[i].s2);
      chk($sformatf("v%0d_d1", i), {16'h0, a_d1}, {16'h0, vecs[i].d1});
      chk($sformatf("v%0d_b1", i), {31'h0, a_b1}, {31'h0, vecs[i].b1});
      chk($sformatf("v%0d_d2", i), {16'h0, a_d2}, {16'h0, vecs[i].d2});
      chk($sformatf("v%0d_b2", i), {31'h0, a_b2}, {31'h0, vecs[i].b2});
      chk($sformatf("v%0d_err", i), {31'h0, a_err}, {31'h0, vecs[i].er});
    end

    // No-bypass instance: same-cycle write is invisible, pre-edge busy shown.
    drive(1, 5, 0, 0, 16'h0000, 0, 5, 5);
    chk("nb_rsv_b1", {31'h0, n_b1}, 32'h0);
    drive(0, 0, 1, 5, 16'hA5A5, 0, 5, 5);
    chk("nb_same_d1", {16'h0, n_d1}, 32'h1234);
    chk("nb_same_b1", {31'h0, n_b1}, 32'h1);
    chk("byp_same_d1", {16'h0, a_d1}, 32'hA5A5);
    chk("byp_same_b1", {31'h0, a_b1}, 32'h0);
    drive(0, 0, 0, 0, 16'h0000, 0, 5, 5);
    chk("nb_next_d2", {16'h0, n_d2}, 32'hA5A5);
    chk("nb_next_b2", {31'h0, n_b2}, 32'h0);
    chk("nb_next_err", {31'h0, a_err}, 32'h0);

    // Zero-register instance: reserve and writes to r0 are ignored without err.
    drive(1, 0, 0, 0, 16'h0000, 0, 0, 0);
    drive(0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
    chk("z_same_d1", {16'h0, z_d1}, 32'h0);
    chk("z_same_b1", {31'h0, z_b1}, 32'h0);
    chk("z_ref_d1", {16'h0, a_d1}, 32'hFFFF);
    drive(0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
    chk("z_next_d1", {16'h0, z_d1}, 32'h0);
    chk("z_next_b1", {31'h0, z_b1}, 32'h0);
    chk("z_next_err", {31'h0, z_err}, 32'h0);
    chk("z_ref_err0", {31'h0, a_err}, 32'h0);
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 4);
    chk("z_last_err", {31'h0, z_err}, 32'h0);
    chk("z_ref_err1", {31'h0, a_err}, 32'h1);
    chk("z_last_d2", {16'h0, z_d2}, 32'h0);

    // Mid-run async reset while err and a busy bit are both set.
    drive(1, 4, 1, 2, 16'h7777, 0, 4, 2);
    drive(0, 0, 0, 0, 16'h0000, 0, 4, 2);
    chk("pre_rst_err", {31'h0, a_err}, 32'h1);
    chk("pre_rst_b1", {31'h0, a_b1}, 32'h1);
    chk("pre_rst_d2", {16'h0, a_d2}, 32'h7777);
    #1 rst = 1'b0;
    #1;
    chk("rst_d1", {16'h0, a_d1}, 32'h0);
    chk("rst_b1", {31'h0, a_b1}, 32'h0);
    chk("rst_d2", {16'h0, a_d2}, 32'h0);
    chk("rst_b2", {31'h0, a_b2}, 32'h0);
    chk("rst_err", {31'h0, a_err}, 32'h0);
    chk("rst_nb_d2", {16'h0, n_d2}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0000, 0, 3, 5);
    chk("post_rst_d1", {16'h0, a_d1}, 32'h0);
    chk("post_rst_d2", {16'h0, a_d2}, 32'h0);
    chk("post_rst_err", {31'h0, a_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
